// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and instruction-fetch sequencer.
// Holds the PC, offers PC+4 to the branch adder, runs a request/ready fetch
// to instruction memory and buffers a redirect that arrives while a fetch
// is outstanding or while downstream stalls.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] pc,
  output logic [31:0] pc_4,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        redirect_pending
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  // Instruction addresses are word aligned; low two bits are always cleared.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  logic [1:0]  state_r;
  logic [1:0]  state_nxt_s;
  logic [31:0] pc_r;
  logic [31:0] pc_nxt_s;
  logic [31:0] instr_r;
  logic [31:0] instr_nxt_s;
  logic        instr_valid_r;
  logic        instr_valid_nxt_s;
  logic        pending_r;
  logic        pending_nxt_s;
  logic [31:0] pending_target_r;
  logic [31:0] pending_target_nxt_s;
  logic        redirect_s;
  logic [31:0] redirect_target_s;
  logic [31:0] pc_inc_s;

  assign pc_inc_s         = pc_r + 32'd4;
  assign pc               = pc_r;
  assign pc_4             = pc_inc_s;
  assign imem_addr        = pc_r;
  assign imem_req         = (state_r == ST_FETCH);
  assign instr            = instr_r;
  assign instr_valid      = instr_valid_r;
  assign redirect_pending = pending_r;

  // Pick the arriving redirect target; a jump outranks a branch.
  always_comb begin
    redirect_s        = jump | branch_taken;
    redirect_target_s = 32'h0000_0000;
    if (jump) begin
      redirect_target_s = word_align(jump_target);
    end else if (branch_taken) begin
      redirect_target_s = word_align(branch_target);
    end else begin
      redirect_target_s = 32'h0000_0000;
    end
  end

  // Sequencer next-state: IDLE -> FETCH <-> HOLD with redirect buffering.
  always_comb begin
    state_nxt_s          = state_r;
    pc_nxt_s             = pc_r;
    instr_nxt_s          = instr_r;
    instr_valid_nxt_s    = instr_valid_r;
    pending_nxt_s        = pending_r;
    pending_target_nxt_s = pending_target_r;
    case (state_r)
      ST_IDLE: begin
        state_nxt_s       = ST_FETCH;
        instr_valid_nxt_s = 1'b0;
      end
      ST_FETCH: begin
        if (imem_ready) begin
          if (redirect_s) begin
            // Response belongs to a stale path; retarget and refetch.
            pc_nxt_s      = redirect_target_s;
            pending_nxt_s = 1'b0;
          end else if (pending_r) begin
            pc_nxt_s      = pending_target_r;
            pending_nxt_s = 1'b0;
          end else begin
            instr_nxt_s       = imem_rdata;
            instr_valid_nxt_s = 1'b1;
            state_nxt_s       = ST_HOLD;
          end
        end else if (redirect_s) begin
          // Address must stay stable while the request is outstanding.
          pending_nxt_s        = 1'b1;
          pending_target_nxt_s = redirect_target_s;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (stall) begin
          if (redirect_s) begin
            pending_nxt_s        = 1'b1;
            pending_target_nxt_s = redirect_target_s;
          end else begin
            pending_nxt_s = pending_r;
          end
        end else begin
          if (redirect_s) begin
            pc_nxt_s = redirect_target_s;
          end else if (pending_r) begin
            pc_nxt_s = pending_target_r;
          end else begin
            pc_nxt_s = pc_inc_s;
          end
          pending_nxt_s     = 1'b0;
          instr_valid_nxt_s = 1'b0;
          state_nxt_s       = ST_FETCH;
        end
      end
      default: begin
        // Unreachable encoding: drop back to a clean restart.
        state_nxt_s       = ST_IDLE;
        instr_valid_nxt_s = 1'b0;
        pending_nxt_s     = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r          <= ST_IDLE;
      pc_r             <= RESET_PC;
      instr_r          <= 32'h0000_0000;
      instr_valid_r    <= 1'b0;
      pending_r        <= 1'b0;
      pending_target_r <= 32'h0000_0000;
    end else begin
      state_r          <= state_nxt_s;
      pc_r             <= pc_nxt_s;
      instr_r          <= instr_nxt_s;
      instr_valid_r    <= instr_valid_nxt_s;
      pending_r        <= pending_nxt_s;
      pending_target_r <= pending_target_nxt_s;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios followed by
// random traffic, all checked against a behavioural model of the sequencer.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, jump, imem_ready;
  logic [31:0] branch_target, jump_target, imem_rdata;
  logic [31:0] pc, pc_4, imem_addr, instr;
  logic        imem_req, instr_valid, redirect_pending;

  // second instance exercising PC wrap-around from the top of memory
  logic [31:0] w_pc, w_pc_4, w_imem_addr, w_instr;
  logic        w_imem_req, w_instr_valid, w_redirect_pending;

  int n_cmp  = 0;
  int n_fail = 0;

  // behavioural model: phase 0 = waiting to start, 1 = fetching, 2 = holding
  int          m_phase;
  logic [31:0] m_pc, m_instr, m_ptgt;
  logic        m_valid, m_pend;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .pc(pc), .pc_4(pc_4), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .redirect_pending(redirect_pending)
  );

  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .reset(reset), .stall(1'b0),
    .branch_taken(1'b0), .branch_target(32'h0000_0000),
    .jump(1'b0), .jump_target(32'h0000_0000),
    .pc(w_pc), .pc_4(w_pc_4), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_ready(1'b1), .imem_rdata(32'h1234_5678),
    .instr(w_instr), .instr_valid(w_instr_valid), .redirect_pending(w_redirect_pending)
  );

  task automatic expect32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_pc    = 32'h0000_0000;
    m_instr = 32'h0000_0000;
    m_valid = 1'b0;
    m_pend  = 1'b0;
    m_ptgt  = 32'h0000_0000;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    logic        redir;
    logic [31:0] tgt;
    redir = jump | branch_taken;
    tgt   = jump ? {jump_target[31:2], 2'b00} : {branch_target[31:2], 2'b00};
    if (reset) begin
      model_reset();
    end else if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (imem_ready && (redir || m_pend)) begin
        m_pc   = redir ? tgt : m_ptgt;
        m_pend = 1'b0;
      end else if (imem_ready) begin
        m_instr = imem_rdata;
        m_valid = 1'b1;
        m_phase = 2;
      end else if (redir) begin
        m_pend = 1'b1;
        m_ptgt = tgt;
      end
    end else begin
      if (stall) begin
        if (redir) begin
          m_pend = 1'b1;
          m_ptgt = tgt;
        end
      end else begin
        m_pc    = redir ? tgt : (m_pend ? m_ptgt : m_pc + 32'd4);
        m_pend  = 1'b0;
        m_valid = 1'b0;
        m_phase = 1;
      end
    end
  endtask

  task automatic check_all();
    expect32("pc", pc, m_pc);
    expect32("pc_4", pc_4, m_pc + 32'd4);
    expect32("imem_addr", imem_addr, m_pc);
    expect32("imem_req", {31'd0, imem_req}, {31'd0, (m_phase == 1)});
    expect32("instr", instr, m_instr);
    expect32("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
    expect32("redirect_pending", {31'd0, redirect_pending}, {31'd0, m_pend});
  endtask

  // One cycle: check current outputs, advance model, cross the edge.
  task automatic tick();
    check_all();
    model_step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    imem_ready = 1'b1; branch_target = 32'h0; jump_target = 32'h0;
    imem_rdata = 32'hA000_0000;
    @(posedge clk);
    #2;
    model_reset();

    // reset held two cycles, then sequential fetch
    tick();
    tick();
    reset = 1'b0;
    tick();                                   // IDLE -> FETCH
    expect32("seq_addr0", imem_addr, 32'h0);
    expect32("seq_req0", {31'd0, imem_req}, 32'd1);
    expect32("wrap_addr0", w_imem_addr, 32'hFFFF_FFFC);
    expect32("wrap_pc4", w_pc_4, 32'h0);
    imem_rdata = 32'hA000_0004;
    tick();                                   // capture -> HOLD
    expect32("seq_valid", {31'd0, instr_valid}, 32'd1);
    tick();
    expect32("seq_addr4", imem_addr, 32'h4);
    expect32("wrap_addr1", w_imem_addr, 32'h0);
    tick();
    tick();
    expect32("seq_addr8", imem_addr, 32'h8);
    tick();                                   // HOLD at pc=8

    // branch redirect from HOLD
    branch_taken = 1'b1; branch_target = 32'h0000_0020;
    tick();
    branch_taken = 1'b0;
    expect32("br_addr", imem_addr, 32'h20);
    tick();
    tick();
    expect32("br_next", imem_addr, 32'h24);
    tick();                                   // HOLD

    // jump beats branch
    branch_taken = 1'b1; branch_target = 32'h40;
    jump = 1'b1; jump_target = 32'h100;
    tick();
    branch_taken = 1'b0; jump = 1'b0;
    expect32("jmp_prio", pc, 32'h100);
    tick();                                   // HOLD at 0x100
    jump = 1'b1; jump_target = 32'h10;
    tick();                                   // FETCH at 0x10
    jump = 1'b0;

    // buffered redirect while memory is busy
    imem_ready = 1'b0;
    tick();
    branch_taken = 1'b1; branch_target = 32'h80;
    tick();
    branch_taken = 1'b0;
    tick();
    expect32("buf_pend", {31'd0, redirect_pending}, 32'd1);
    expect32("buf_addr", imem_addr, 32'h10);
    imem_ready = 1'b1;
    tick();
    expect32("buf_valid", {31'd0, instr_valid}, 32'd0);
    expect32("buf_newaddr", imem_addr, 32'h80);
    expect32("buf_clr", {31'd0, redirect_pending}, 32'd0);

    // stall hold with a misaligned jump arriving mid-stall
    imem_rdata = 32'hC0DE_0080;
    tick();                                   // HOLD, instr captured
    stall = 1'b1;
    tick();
    jump = 1'b1; jump_target = 32'h203;
    tick();
    jump = 1'b0;
    tick();
    tick();
    expect32("stall_instr", instr, 32'hC0DE_0080);
    expect32("stall_pc", pc, 32'h80);
    expect32("stall_pend", {31'd0, redirect_pending}, 32'd1);
    stall = 1'b0;
    tick();
    expect32("stall_jmp", pc, 32'h200);

    // reset while a fetch is outstanding
    expect32("mid_req", {31'd0, imem_req}, 32'd1);
    reset = 1'b1;
    tick();
    expect32("mid_pc", pc, 32'h0);
    expect32("mid_req0", {31'd0, imem_req}, 32'd0);
    expect32("mid_instr", instr, 32'h0);
    expect32("mid_valid", {31'd0, instr_valid}, 32'd0);
    expect32("mid_pend", {31'd0, redirect_pending}, 32'd0);
    expect32("mid_wpc", w_pc, 32'hFFFF_FFFC);
    reset = 1'b0;

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      stall         = ($urandom_range(0, 2) == 0);
      branch_taken  = ($urandom_range(0, 5) == 0);
      jump          = ($urandom_range(0, 7) == 0);
      branch_target = $urandom;
      jump_target   = $urandom;
      imem_ready    = ($urandom_range(0, 2) != 0);
      imem_rdata    = $urandom;
      reset         = ($urandom_range(0, 63) == 0);
      tick();
    end
    check_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter and instruction-fetch sequencer for the single-cycle MIPS datapath. It holds the PC and produces `pc_4` (PC+4), which the branch adder uses as its base operand. It accepts the branch adder's result back as a redirect target and issues a request/ready fetch to instruction memory. A redirect that arrives while the fetch cannot accept it is buffered and applied at the next legal point.

## Interface

**Parameters**
- `RESET_PC`, default `32'h0000_0000`: PC value loaded on reset. Bits [1:0] must be 0.

**Ports**
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `reset`, in, 1: synchronous, active-high.
- `stall`, in, 1: downstream cannot consume the held instruction.
- `branch_taken`, in, 1: take a branch to `branch_target` this cycle.
- `branch_target`, in, 32: branch adder result (`pc_4` + shifted immediate).
- `jump`, in, 1: take a jump to `jump_target` this cycle.
- `jump_target`, in, 32: absolute jump address.
- `pc`, out, 32: address of the current or held instruction.
- `pc_4`, out, 32: combinational `pc + 4`, modulo 2^32.
- `imem_req`, out, 1: fetch request to instruction memory.
- `imem_addr`, out, 32: fetch address; always equals `pc`.
- `imem_ready`, in, 1: memory returns data on `imem_rdata` this cycle.
- `imem_rdata`, in, 32: fetched instruction word.
- `instr`, out, 32: registered instruction.
- `instr_valid`, out, 1: `instr` is valid for the instruction at `pc`.
- `redirect_pending`, out, 1: a buffered redirect is waiting to be applied.

## Operation

- **Reset values:** state=IDLE; `pc`=`RESET_PC`; `instr`=0; `instr_valid`=0; `imem_req`=0; `redirect_pending`=0; pending target=0.
- **Target alignment:** redirect targets are written with bits [1:0] forced to 0.
- **Redirect selection:** if `jump` and `branch_taken` are asserted in the same cycle, the jump wins.
- **State IDLE:** `imem_req`=0. Moves unconditionally to FETCH on the next cycle.
- **State FETCH:** `imem_req`=1 and `imem_addr`=`pc`. Stays in FETCH until `imem_ready`. On `imem_ready`:
  - If no redirect is pending and none arrives this cycle: `instr`←`imem_rdata`, `instr_valid`←1, go to HOLD.
  - If a redirect is pending, or one arrives this cycle: discard `imem_rdata`, `pc`←target (an arriving redirect overrides the buffered one), clear `redirect_pending`, stay in FETCH.
- **Redirect in FETCH without `imem_ready`:** latch the target and set `redirect_pending`. A later redirect overwrites the latched target. `pc` does not change while the request is outstanding.
- **State HOLD:** `instr_valid`=1 and `imem_req`=0.
  - `stall`=1: hold `pc` and `instr`. An arriving redirect is latched into pending (newest wins).
  - `stall`=0: `pc`← arriving redirect target, else pending target, else `pc_4`. Then clear `redirect_pending`, `instr_valid`←0, go to FETCH.
- **Reset mid-operation:** returns to reset values on the next edge. Any outstanding memory response is ignored, because `imem_ready` is only sampled in FETCH.
- **Wrap-around:** `pc`=`32'hFFFF_FFFC` advances to `32'h0000_0000`.

## Timing

- `pc_4` is combinational from `pc`. All other outputs are registered or decoded from state.
- **Fetch latency:** `imem_req` rises 1 cycle after `reset` falls. `instr_valid` rises on the edge that samples `imem_ready`=1.
- **Throughput:** with `imem_ready` tied high and `stall`=0, one instruction every 2 cycles (FETCH, HOLD).
- **Redirect latency:** a redirect in HOLD with `stall`=0 appears on `imem_addr` in the next cycle. A buffered redirect costs one extra FETCH cycle for the discarded response.
- `imem_addr` is stable while `imem_req`=1 and `imem_ready`=0.

## Test plan

- **Reset and sequential fetch.** Hold `reset` for 2 cycles with `imem_ready`=1 and `stall`=0, then release. Required: `imem_addr` sequence 0, 4, 8, 12. `instr_valid` pulses every second cycle. `pc_4`=`pc`+4.
- **Branch redirect.** In HOLD at `pc`=8, assert `branch_taken` with `branch_target`=`32'h0000_0020` and `stall`=0. Required: next `imem_addr`=`32'h20`, then 0x24.
- **Jump priority.** In HOLD, assert `branch_taken` (target 0x40) and `jump` (target 0x100) together. Required: `pc`=0x100.
- **Buffered redirect.** With `imem_ready`=0 for 3 cycles at `pc`=0x10, pulse `branch_taken` with target 0x80. Required: `redirect_pending`=1, `imem_addr` stays 0x10. Then raise `imem_ready`. Required: response discarded, `instr_valid` stays 0, next `imem_addr`=0x80, `redirect_pending`=0.
- **Stall hold.** In HOLD, assert `stall` for 4 cycles and pulse `jump` (target 0x200, written with bits [1:0] set, e.g. 0x203) during the stall. Required: `instr` and `pc` stable, `redirect_pending`=1. After `stall` drops, `pc`=0x200 with the low bits cleared.
- **Wrap and mid-fetch reset.** With `RESET_PC`=`32'hFFFF_FFFC`, the second `imem_addr` is 0. Assert `reset` while `imem_req`=1. Required: all outputs return to their reset values on the next edge.
